// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types for the byte-serial data-memory sequencer:
//               access-mode encoding, FSM states and beat-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [2:0] {
    MODE_BYTE  = 3'b000,
    MODE_HALF  = 3'b001,
    MODE_WORD  = 3'b010,
    MODE_UBYTE = 3'b011,
    MODE_UHALF = 3'b100
  } mem_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Number of byte beats for a mode; 0 flags an encoding with no meaning.
  function automatic logic [2:0] beats_of(input mem_mode_e m);
    case (m)
      MODE_BYTE, MODE_UBYTE: beats_of = 3'd1;
      MODE_HALF, MODE_UHALF: beats_of = 3'd2;
      MODE_WORD:             beats_of = 3'd4;
      default:               beats_of = 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : dmem_load_extend
// Description : Sign/zero extension of the assembled little-endian load data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] asm_data,
  input  logic [2:0]  mode,
  output logic [31:0] rdata
);

  // Extend from the width implied by the access mode.
  always_comb begin
    rdata = asm_data;
    case (mode)
      MODE_BYTE:  rdata = {{24{asm_data[7]}}, asm_data[7:0]};
      MODE_UBYTE: rdata = {24'h0, asm_data[7:0]};
      MODE_HALF:  rdata = {{16{asm_data[15]}}, asm_data[15:0]};
      MODE_UHALF: rdata = {16'h0, asm_data[15:0]};
      default:    rdata = asm_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Load/store sequencer splitting word/halfword accesses into
//               little-endian byte beats on a single-port byte memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 100,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_mode,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e      state;
  logic        wr;
  logic [2:0]  mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  nbeats;
  logic [1:0]  beat;
  logic        err;
  logic        rd_pend;     // a read was issued last cycle; its byte arrives now
  logic [1:0]  cap_idx;     // byte lane for the arriving read byte
  logic [31:0] asm_q;
  logic [31:0] asm_nxt;
  logic [31:0] rdata_q;
  logic [31:0] ext_data;

  logic [2:0]  req_n;
  logic [32:0] req_last;
  logic        req_err;
  logic        last_beat;
  logic        issuing;

  // Range check in 33 bits so an address near 2^32 cannot wrap into range.
  always_comb begin
    req_n    = beats_of(mem_mode_e'(req_mode));
    req_last = {1'b0, req_addr} + 33'(req_n) - 33'd1;
    req_err  = (req_n == 3'd0) || (req_last >= 33'(MEM_BYTES));
  end

  // Merge the byte returning from memory into the assembly register.
  always_comb begin
    asm_nxt = asm_q;
    if (rd_pend) begin
      asm_nxt[{cap_idx, 3'b000} +: 8] = mem_rdata;
    end
  end

  dmem_load_extend u_ext (
    .asm_data (asm_nxt),
    .mode     (mode),
    .rdata    (ext_data)
  );

  assign last_beat = ({1'b0, beat} == (nbeats - 3'd1));
  assign issuing   = (state == ST_ISSUE);

  // Sequencer state, request latch and load-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr      <= 1'b0;
      mode    <= 3'd0;
      addr    <= 32'd0;
      wdata   <= 32'd0;
      nbeats  <= 3'd0;
      beat    <= 2'd0;
      err     <= 1'b0;
      rd_pend <= 1'b0;
      cap_idx <= 2'd0;
      asm_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      rd_pend <= issuing && !wr;
      cap_idx <= beat;
      if (rd_pend) begin
        asm_q <= asm_nxt;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr     <= req_wr;
            mode   <= req_mode;
            addr   <= req_addr;
            wdata  <= req_wdata;
            nbeats <= req_n;
            beat   <= 2'd0;
            err    <= req_err;
            asm_q  <= 32'd0;
            if (req_err) begin
              state <= ST_RESP;
              if (!req_wr) begin
                rdata_q <= 32'd0;
              end
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (last_beat) begin
            state <= wr ? ST_RESP : ST_DRAIN;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        ST_DRAIN: begin
          rdata_q <= ext_data;
          state   <= ST_RESP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    rsp_err   = rsp_valid && err;
    rsp_rdata = rdata_q;
    mem_wr_en = issuing && wr;
    mem_rd_en = issuing && !wr;
    mem_addr  = issuing ? ADDR_W'(addr + 32'(beat)) : '0;
    mem_wdata = mem_wr_en ? wdata[{beat, 3'b000} +: 8] : 8'h00;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed vector bench for dmem_ctrl with a byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  dmem_ctrl #(.MEM_BYTES(100), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory, synchronous read with one cycle of latency.
  logic [7:0] mem [0:99];
  initial for (int i = 0; i < 100; i++) mem[i] <= 8'(i);
  always @(posedge clk) begin
    if (mem_wr_en && mem_addr < 32'd100) mem[mem_addr[6:0]] <= mem_wdata;
    if (mem_rd_en && mem_addr < 32'd100) mem_rdata <= mem[mem_addr[6:0]];
  end

  // Edge counter plus write log / strobe / response counters.
  int         cyc = 0;
  int         strb_cnt = 0;
  int         rsp_cnt = 0;
  logic [31:0] wl_addr[$];
  logic [7:0]  wl_data[$];
  int          wl_cyc[$];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_wr_en) begin
      wl_addr.push_back(mem_addr);
      wl_data.push_back(mem_wdata);
      wl_cyc.push_back(cyc);
    end
    if (mem_rd_en || mem_wr_en) strb_cnt = strb_cnt + 1;
    if (rsp_valid) rsp_cnt = rsp_cnt + 1;
  end

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response pulse.
  task automatic do_req(input logic wr, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int acc);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_mode = mode; req_addr = addr; req_wdata = wdata;
    strb_cnt = 0;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) begin
      nvec++; nfail++;
      $display("FAIL rsp_timeout: got no rsp_valid, expected one within 20 cycles");
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          strb;
  } vec_t;

  vec_t vt[15];
  int   lat, acc, acc0, rsp_before;
  logic [31:0] w0;

  initial begin
    vt[0]  = '{1'b1, 3'd2, 32'd8,  32'hDEADBEEF, 1'b0, 32'h00000000, 5, 4};
    vt[1]  = '{1'b0, 3'd0, 32'd8,  32'h0,        1'b0, 32'hFFFFFFEF, 3, 1};
    vt[2]  = '{1'b0, 3'd3, 32'd8,  32'h0,        1'b0, 32'h000000EF, 3, 1};
    vt[3]  = '{1'b0, 3'd1, 32'd10, 32'h0,        1'b0, 32'hFFFFDEAD, 4, 2};
    vt[4]  = '{1'b0, 3'd4, 32'd10, 32'h0,        1'b0, 32'h0000DEAD, 4, 2};
    vt[5]  = '{1'b0, 3'd2, 32'd8,  32'h0,        1'b0, 32'hDEADBEEF, 6, 4};
    vt[6]  = '{1'b0, 3'd7, 32'd0,  32'h0,        1'b1, 32'h00000000, 1, 0};
    vt[7]  = '{1'b0, 3'd2, 32'd98, 32'h0,        1'b1, 32'h00000000, 1, 0};
    vt[8]  = '{1'b0, 3'd2, 32'd96, 32'h0,        1'b0, 32'h63626160, 6, 4};
    vt[9]  = '{1'b1, 3'd1, 32'd98, 32'h1234A5C3, 1'b0, 32'h63626160, 3, 2};
    vt[10] = '{1'b0, 3'd1, 32'd98, 32'h0,        1'b0, 32'hFFFFA5C3, 4, 2};
    vt[11] = '{1'b1, 3'd0, 32'd100,32'h00000055, 1'b1, 32'hFFFFA5C3, 1, 0};
    vt[12] = '{1'b0, 3'd2, 32'd9,  32'h0,        1'b0, 32'h0CDEADBE, 6, 4};
    vt[13] = '{1'b0, 3'd5, 32'd0,  32'h0,        1'b1, 32'h00000000, 1, 0};
    vt[14] = '{1'b0, 3'd2, 32'hFFFFFFFE, 32'h0,  1'b1, 32'h00000000, 1, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_mode = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    acc0 = 0;
    for (int i = 0; i < 15; i++) begin
      do_req(vt[i].wr, vt[i].mode, vt[i].addr, vt[i].wdata, lat, acc);
      if (i == 0) acc0 = acc;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, vt[i].err});
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vt[i].rdata);
      chk($sformatf("v%0d_strobes", i), 32'(strb_cnt), 32'(vt[i].strb));
    end

    // Word store beat order and timing: lanes 0..3 on cycles T+1..T+4.
    w0 = 32'hDEADBEEF;
    chk("wlog_len", {31'd0, wl_addr.size() >= 4}, 32'd1);
    if (wl_addr.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wlog%0d_addr", i), wl_addr[i], 32'(8 + i));
        chk($sformatf("wlog%0d_data", i), {24'd0, wl_data[i]}, {24'd0, w0[8*i +: 8]});
        chk($sformatf("wlog%0d_cycle", i), 32'(wl_cyc[i]), 32'(acc0 + 1 + i));
      end
    end

    // Asynchronous reset during beat 2 of a word store.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_mode = 3'd2; req_addr = 32'd8; req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_before = rsp_cnt;
    repeat (3) @(negedge clk);
    chk("abort_beat2_addr", mem_addr, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("abort_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt - rsp_before), 32'd0);
    chk("abort_mem8", {24'd0, mem[8]}, 32'h44);
    chk("abort_mem9", {24'd0, mem[9]}, 32'h33);
    chk("abort_mem10", {24'd0, mem[10]}, 32'hAD);
    chk("abort_mem11", {24'd0, mem[11]}, 32'hDE);
    do_req(1'b1, 3'd0, 32'd20, 32'h0000005A, lat, acc);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_err", {31'd0, rsp_err}, 32'd0);
    chk("post_rst_mem20", {24'd0, mem[20]}, 32'h5A);

    // Back-to-back stores with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_mode = 3'd0; req_addr = 32'd30; req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_addr = 32'd31; req_wdata = 32'h88;
    @(negedge clk);
    chk("b2b_ready_t1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_rsp1", {30'd0, rsp_valid, req_ready}, 32'd2);
    @(negedge clk);
    chk("b2b_ready_t3", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_t4", {30'd0, rsp_valid, req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_rsp2", {30'd0, rsp_valid, rsp_err}, 32'd2);
    chk("b2b_mem30", {24'd0, mem[30]}, 32'h77);
    chk("b2b_mem31", {24'd0, mem[31]}, 32'h88);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
